line_ram_ctrl: RTL

//  Parametrised cache-line-wide main memory with valid/ready request and response channels.

---
 rtl/line_ram_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/line_ram_ctrl.sv
// Line-wide main memory with in-order read response FIFO, a word programming port
// and a hardware clear engine that zeroes one line per cycle.
module line_ram_ctrl #(
    parameter int unsigned LINE_W      = 128,
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned DEPTH_WORDS = 32768,
    parameter int unsigned RD_LATENCY  = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic                           req_we_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] req_addr_i,
    input  logic [LINE_W-1:0]              req_wdata_i,
    input  logic [LINE_W/8-1:0]            req_wstrb_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [LINE_W-1:0]              rsp_rdata_o,
    input  logic                           prog_valid_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] prog_addr_i,
    input  logic [WORD_W-1:0]              prog_data_i,
    input  logic                           prog_mode_i,
    input  logic                           clear_i,
    output logic                           busy_o,
    output logic                           clear_done_o
);

    localparam int unsigned WPL       = LINE_W / WORD_W;
    localparam int unsigned LINES     = DEPTH_WORDS / WPL;
    localparam int unsigned ADDR_W    = $clog2(DEPTH_WORDS);
    localparam int unsigned OFF_W     = $clog2(WPL);
    localparam int unsigned LINE_AW   = ADDR_W - OFF_W;
    localparam int unsigned NBYTES    = LINE_W / 8;
    localparam int unsigned WBYTES    = WORD_W / 8;
    localparam int unsigned RSP_DEPTH = RD_LATENCY + 2;
    localparam int unsigned PTR_W     = $clog2(RSP_DEPTH);
    localparam int unsigned CNT_W     = $clog2(RSP_DEPTH + 1);

    typedef enum logic {
        S_RUN,
        S_CLEAR
    } state_e;

    state_e               state_q, state_d;
    logic [LINE_AW-1:0]   clr_ptr_q, clr_ptr_d;
    logic                 clear_done_q, clear_done_d;
    logic                 clr_we;
    logic [CNT_W-1:0]     credits_q, credits_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [LINE_W-1:0]    mem_q [LINES];
    logic [LINE_W-1:0]    fifo_q [RSP_DEPTH];

    logic [LINE_AW-1:0]   req_line;
    logic [LINE_AW-1:0]   prog_line;
    logic [ADDR_W-1:0]    prog_off;
    logic                 rd_fire;
    logic                 wr_fire;
    logic                 rsp_pop;
    logic [LINE_W-1:0]    rd_line_data;
    logic                 push_vld;
    logic [LINE_W-1:0]    push_dat;

    logic [LINE_AW-1:0]   mem_waddr;
    logic [LINE_W-1:0]    mem_wdata;
    logic [NBYTES-1:0]    mem_wmask;

    always_comb begin
        req_line     = LINE_AW'(req_addr_i >> OFF_W);
        prog_line    = LINE_AW'(prog_addr_i >> OFF_W);
        prog_off     = prog_addr_i & ADDR_W'(WPL - 1);
        req_ready_o  = !rst_i && (state_q == S_RUN) && !prog_mode_i && !prog_valid_i &&
                       (req_we_i || (credits_q < CNT_W'(RSP_DEPTH)));
        rd_fire      = req_valid_i && req_ready_o && !req_we_i;
        wr_fire      = req_valid_i && req_ready_o && req_we_i;
        rsp_valid_o  = (cnt_q != '0);
        rsp_pop      = rsp_valid_o && rsp_ready_i;
        rsp_rdata_o  = fifo_q[rd_ptr_q];
        rd_line_data = mem_q[req_line];
        busy_o       = (state_q == S_CLEAR);
        clear_done_o = clear_done_q;
    end

    // Clear engine FSM
    always_comb begin
        state_d      = state_q;
        clr_ptr_d    = clr_ptr_q;
        clear_done_d = 1'b0;
        clr_we       = 1'b0;
        case (state_q)
            S_RUN: begin
                if (clear_i && !prog_mode_i) begin
                    state_d   = S_CLEAR;
                    clr_ptr_d = '0;
                end
            end
            S_CLEAR: begin
                clr_we = 1'b1;
                if (clr_ptr_q == LINE_AW'(LINES - 1)) begin
                    state_d      = S_RUN;
                    clear_done_d = 1'b1;
                end else begin
                    clr_ptr_d = clr_ptr_q + LINE_AW'(1);
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    // Single array write port: programming beats clearing; requests only write in S_RUN
    always_comb begin
        mem_waddr = req_line;
        mem_wdata = req_wdata_i;
        mem_wmask = '0;
        if (prog_valid_i) begin
            mem_waddr = prog_line;
            mem_wdata = {WPL{prog_data_i}};
            for (int b = 0; b < NBYTES; b++) begin
                mem_wmask[b] = ((b / WBYTES) == int'(prog_off));
            end
        end else if (clr_we) begin
            mem_waddr = clr_ptr_q;
            mem_wdata = '0;
            mem_wmask = '1;
        end else if (wr_fire) begin
            mem_wmask = req_wstrb_i;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NBYTES; b++) begin
            if (mem_wmask[b]) begin
                mem_q[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // Read latency pipeline: the array is sampled at accept, FIFO written RD_LATENCY-1 edges later
    if (RD_LATENCY == 1) begin : g_lat1
        assign push_vld = rd_fire;
        assign push_dat = rd_line_data;
    end else begin : g_pipe
        localparam int unsigned PN = RD_LATENCY - 1;
        logic [PN-1:0]     vld_q, vld_d;
        logic [LINE_W-1:0] dat_q [PN];
        logic [LINE_W-1:0] dat_d [PN];

        always_comb begin
            vld_d    = PN'({vld_q, rd_fire});
            dat_d[0] = rd_line_data;
            for (int k = 1; k < PN; k++) begin
                dat_d[k] = dat_q[k-1];
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                vld_q <= '0;
            end else begin
                vld_q <= vld_d;
            end
        end

        always_ff @(posedge clk_i) begin
            dat_q <= dat_d;
        end

        assign push_vld = vld_q[PN-1];
        assign push_dat = dat_q[PN-1];
    end

    // Credits bound in-flight reads plus FIFO occupancy, so the FIFO can never overflow
    always_comb begin
        credits_d = credits_q + CNT_W'(rd_fire) - CNT_W'(rsp_pop);
        cnt_d     = cnt_q + CNT_W'(push_vld) - CNT_W'(rsp_pop);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (push_vld) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (rsp_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_vld) begin
            fifo_q[wr_ptr_q] <= push_dat;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_RUN;
            clr_ptr_q    <= '0;
            clear_done_q <= 1'b0;
            credits_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            clear_done_q <= clear_done_d;
            credits_q    <= credits_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule
